// File: rtl/baccarat_table_fsm.sv
// Baccarat table controller: deals one banker hand against NUM_PLAYERS player hands from a
// valid/ready card source, applies natural and third-card rules and reports per-player results.
module baccarat_table_fsm #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned RND_W       = 8
) (
  input  logic                     clk_i,
  input  logic                     resetb_i,
  input  logic                     start_i,
  input  logic                     card_valid_i,
  input  logic [3:0]               card_value_i,
  output logic                     card_ready_o,
  output logic [2:0]               deal_hand_o,
  output logic [1:0]               deal_slot_o,
  output logic                     deal_strobe_o,
  output logic [4*NUM_PLAYERS-1:0] pscore_o,
  output logic [3:0]               dscore_o,
  output logic [NUM_PLAYERS-1:0]   player_win_o,
  output logic [NUM_PLAYERS-1:0]   dealer_win_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     illegal_card_o,
  output logic [RND_W-1:0]         round_count_o
);
  localparam logic [2:0] Banker = 3'(NUM_PLAYERS);

  typedef enum logic [2:0] {
    StIdle, StDeal, StCheck, StDrawP, StBDecide, StDrawB, StResolve, StDone
  } state_e;

  state_e                 state_q;
  logic                   ready_q, strobe_q, busy_q, done_q, illegal_q, p0_drew_q, slot_q;
  logic [2:0]             hand_q, deal_hand_q;
  logic [1:0]             deal_slot_q;
  logic [3:0]             ps_q [NUM_PLAYERS];
  logic [3:0]             ds_q, third_q;
  logic [NUM_PLAYERS-1:0] pend_q, pw_q, dw_q;
  logic [RND_W-1:0]       round_q;

  logic                   xfer, card_bad, bank_draw;
  logic [3:0]             card_val, cur_score, new_score;
  logic [4:0]             sum;
  logic [2:0]             cur_hand;
  logic [1:0]             cur_slot;
  logic [NUM_PLAYERS-1:0] pend_next, draw_c;

  assign xfer     = ready_q & card_valid_i;
  assign card_bad = (card_value_i == 4'd0) || (card_value_i >= 4'd14);
  assign card_val = (card_value_i <= 4'd9) ? card_value_i : 4'd0;

  // Hand/slot receiving a card this cycle; in DRAW_P the lowest pending player goes first.
  always_comb begin
    cur_hand = hand_q;
    cur_slot = {1'b0, slot_q};
    if (state_q == StDrawP) begin
      cur_slot = 2'd2;
      for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
        if (pend_q[i]) cur_hand = 3'(i);
      end
    end else if (state_q == StDrawB) begin
      cur_hand = Banker;
      cur_slot = 2'd2;
    end
    cur_score = ds_q;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      if (cur_hand == 3'(i)) cur_score = ps_q[i];
    end
    sum       = {1'b0, cur_score} + {1'b0, card_val};
    new_score = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      pend_next[i] = pend_q[i] && (cur_hand != 3'(i));
      draw_c[i]    = (ps_q[i] <= 4'd5);
    end
  end

  // Banker third-card rule, keyed to player 0.
  always_comb begin
    bank_draw = 1'b0;
    if (!p0_drew_q) begin
      bank_draw = (ps_q[0] < 4'd8) && (ds_q <= 4'd5);
    end else begin
      case (ds_q)
        4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
        4'd3:             bank_draw = (third_q != 4'd8);
        4'd4:             bank_draw = (third_q >= 4'd2) && (third_q <= 4'd7);
        4'd5:             bank_draw = (third_q >= 4'd4) && (third_q <= 4'd7);
        4'd6:             bank_draw = (third_q >= 4'd6) && (third_q <= 4'd7);
        default:          bank_draw = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (resetb_i) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      p0_drew_q   <= 1'b0;
      slot_q      <= 1'b0;
      hand_q      <= '0;
      deal_hand_q <= '0;
      deal_slot_q <= '0;
      for (int i = 0; i < int'(NUM_PLAYERS); i++) ps_q[i] <= '0;
      ds_q        <= '0;
      third_q     <= '0;
      pend_q      <= '0;
      pw_q        <= '0;
      dw_q        <= '0;
      round_q     <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (xfer) begin
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
          if (cur_hand == 3'(i)) ps_q[i] <= new_score;
        end
        if (cur_hand == Banker) ds_q <= new_score;
        if (card_bad) illegal_q <= 1'b1;
        strobe_q    <= 1'b1;
        deal_hand_q <= cur_hand;
        deal_slot_q <= cur_slot;
      end
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            for (int i = 0; i < int'(NUM_PLAYERS); i++) ps_q[i] <= '0;
            ds_q      <= '0;
            pw_q      <= '0;
            dw_q      <= '0;
            illegal_q <= 1'b0;
            p0_drew_q <= 1'b0;
            pend_q    <= '0;
            third_q   <= '0;
            hand_q    <= '0;
            slot_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= StDeal;
          end
        end
        StDeal: begin
          if (xfer) begin
            if (hand_q == Banker) begin
              hand_q <= '0;
              if (slot_q) begin
                ready_q <= 1'b0;
                state_q <= StCheck;
              end else begin
                slot_q <= 1'b1;
              end
            end else begin
              hand_q <= hand_q + 3'd1;
            end
          end
        end
        StCheck: begin
          if (ds_q >= 4'd8) begin
            state_q <= StResolve;
          end else begin
            p0_drew_q <= draw_c[0];
            pend_q    <= draw_c;
            if (|draw_c) begin
              ready_q <= 1'b1;
              state_q <= StDrawP;
            end else begin
              state_q <= StBDecide;
            end
          end
        end
        StDrawP: begin
          if (xfer) begin
            if (cur_hand == 3'd0) third_q <= card_val;
            pend_q <= pend_next;
            if (pend_next == '0) begin
              ready_q <= 1'b0;
              state_q <= StBDecide;
            end
          end
        end
        StBDecide: begin
          if (bank_draw) begin
            ready_q <= 1'b1;
            state_q <= StDrawB;
          end else begin
            state_q <= StResolve;
          end
        end
        StDrawB: begin
          if (xfer) begin
            ready_q <= 1'b0;
            state_q <= StResolve;
          end
        end
        StResolve: begin
          for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            pw_q[i] <= (ps_q[i] >= ds_q);
            dw_q[i] <= (ps_q[i] <= ds_q);
          end
          round_q <= round_q + 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    pscore_o = '0;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) pscore_o[4*i +: 4] = ps_q[i];
  end

  assign card_ready_o   = ready_q;
  assign deal_hand_o    = deal_hand_q;
  assign deal_slot_o    = deal_slot_q;
  assign deal_strobe_o  = strobe_q;
  assign dscore_o       = ds_q;
  assign player_win_o   = pw_q;
  assign dealer_win_o   = dw_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign illegal_card_o = illegal_q;
  assign round_count_o  = round_q;

endmodule

// File: tb/tb_baccarat_table_fsm.sv
// Scoreboard bench for baccarat_table_fsm: a card-list game model predicts every dealt card and
// each round result; a monitor compares them against the DUT as they appear.
module tb_baccarat_table_fsm;
  localparam int NP     = 2;
  localparam int RW     = 2;
  localparam int Budget = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetb, start, card_valid;
  logic [3:0]    card_value;
  logic          card_ready, deal_strobe, busy, done, illegal_card;
  logic [2:0]    deal_hand;
  logic [1:0]    deal_slot;
  logic [4*NP-1:0] pscore;
  logic [3:0]    dscore;
  logic [NP-1:0] player_win, dealer_win;
  logic [RW-1:0] round_count;

  baccarat_table_fsm #(.NUM_PLAYERS(NP), .RND_W(RW)) dut (
    .clk_i         (clk),
    .resetb_i      (resetb),
    .start_i       (start),
    .card_valid_i  (card_valid),
    .card_value_i  (card_value),
    .card_ready_o  (card_ready),
    .deal_hand_o   (deal_hand),
    .deal_slot_o   (deal_slot),
    .deal_strobe_o (deal_strobe),
    .pscore_o      (pscore),
    .dscore_o      (dscore),
    .player_win_o  (player_win),
    .dealer_win_o  (dealer_win),
    .busy_o        (busy),
    .done_o        (done),
    .illegal_card_o(illegal_card),
    .round_count_o (round_count)
  );

  typedef struct { int hand; int slot; int score; } ev_t;
  typedef struct {
    logic [4*NP-1:0] ps;
    logic [3:0]      ds;
    logic [NP-1:0]   pw;
    logic [NP-1:0]   dw;
    logic            ill;
    logic [RW-1:0]   rc;
  } res_t;

  ev_t  evq[$];
  res_t resq[$];
  int   checks = 0;
  int   errors = 0;
  int   rounds_done = 0;
  int   cards [16];
  logic busy_p = 1'b0;
  logic done_p = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int take(inout int idx, inout bit ill);
    int r = cards[idx];
    idx++;
    if (r == 0 || r > 13) ill = 1'b1;
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  // Plays the round from cards[] by the game rules; queues expected cards and result.
  task automatic model_round();
    int   p [NP];
    bit   drew [NP];
    int   b = 0, idx = 0, t0 = 0, v;
    bit   ill = 1'b0, bd = 1'b0;
    ev_t  e;
    res_t r;
    for (int i = 0; i < NP; i++) begin p[i] = 0; drew[i] = 1'b0; end
    for (int s = 0; s < 2; s++) begin
      for (int h = 0; h <= NP; h++) begin
        v = take(idx, ill);
        if (h < NP) begin p[h] = (p[h] + v) % 10; e.score = p[h]; end
        else begin b = (b + v) % 10; e.score = b; end
        e.hand = h; e.slot = s; evq.push_back(e);
      end
    end
    if (b < 8) begin
      for (int i = 0; i < NP; i++) drew[i] = (p[i] <= 5);
      for (int i = 0; i < NP; i++) begin
        if (drew[i]) begin
          v = take(idx, ill);
          if (i == 0) t0 = v;
          p[i] = (p[i] + v) % 10;
          e.hand = i; e.slot = 2; e.score = p[i]; evq.push_back(e);
        end
      end
      if (!drew[0]) bd = (p[0] < 8) && (b <= 5);
      else bd = (b <= 2) || (b == 3 && t0 != 8) || (b == 4 && t0 >= 2 && t0 <= 7) ||
                (b == 5 && t0 >= 4 && t0 <= 7) || (b == 6 && t0 >= 6 && t0 <= 7);
      if (bd) begin
        v = take(idx, ill);
        b = (b + v) % 10;
        e.hand = NP; e.slot = 2; e.score = b; evq.push_back(e);
      end
    end
    rounds_done++;
    for (int i = 0; i < NP; i++) begin
      r.ps[4*i +: 4] = 4'(p[i]);
      r.pw[i] = (p[i] >= b);
      r.dw[i] = (p[i] <= b);
    end
    r.ds  = 4'(b);
    r.ill = ill;
    r.rc  = RW'(rounds_done);
    resq.push_back(r);
  endtask

  task automatic rand_cards();
    int r;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        r = int'($urandom_range(0, 2));
        cards[i] = (r == 0) ? 0 : 13 + r;
      end else begin
        cards[i] = int'($urandom_range(1, 13));
      end
    end
  endtask

  task automatic check_reset();
    chk("rst_card_ready", card_ready, 0);
    chk("rst_strobe", deal_strobe, 0);
    chk("rst_deal_hand_slot", {deal_hand, deal_slot}, 0);
    chk("rst_pscore", pscore, 0);
    chk("rst_dscore", dscore, 0);
    chk("rst_lights", {player_win, dealer_win}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_illegal", illegal_card, 0);
    chk("rst_round_count", round_count, 0);
  endtask

  // mode 0: valid always high, 1: valid pattern 1-0-0-1, other: random valid
  task automatic run_round(input int mode);
    int k = 0, cyc = 0;
    model_round();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("illegal_cleared_by_start", illegal_card, 0);
    while (!done && cyc < Budget) begin
      card_value = 4'(cards[k]);
      case (mode)
        0:       card_valid = 1'b1;
        1:       card_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: card_valid = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (card_ready && card_valid && k < 15) k++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= Budget) begin
      checks++; errors++;
      $display("FAIL round_timeout: done not seen after %0d cycles, required within %0d", cyc, Budget);
    end
    // Cards offered while DONE must not be taken.
    card_valid = 1'b1;
    repeat (3) @(negedge clk);
    card_valid = 1'b0;
    chk("leftover_expected_cards", evq.size(), 0);
    chk("leftover_expected_results", resq.size(), 0);
  endtask

  initial begin : monitor
    int   eps [NP];
    int   eds;
    ev_t  e;
    res_t r;
    eds = 0;
    for (int i = 0; i < NP; i++) eps[i] = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_p) begin
        eds = 0;
        for (int i = 0; i < NP; i++) eps[i] = 0;
      end
      if (deal_strobe) begin
        if (evq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_card: hand=%0d slot=%0d, required no card", deal_hand, deal_slot);
        end else begin
          e = evq.pop_front();
          chk("deal_hand", deal_hand, e.hand);
          chk("deal_slot", deal_slot, e.slot);
          if (e.hand == NP) eds = e.score; else eps[e.hand] = e.score;
        end
      end
      if (busy) begin
        chk("live_dscore", dscore, eds);
        for (int i = 0; i < NP; i++) chk("live_pscore", pscore[4*i +: 4], eps[i]);
      end
      if (done && !done_p) begin
        if (resq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done rose, required no finished round");
        end else begin
          r = resq.pop_front();
          chk("final_pscore", pscore, r.ps);
          chk("final_dscore", dscore, r.ds);
          chk("player_win", player_win, r.pw);
          chk("dealer_win", dealer_win, r.dw);
          chk("illegal_card", illegal_card, r.ill);
          chk("round_count", round_count, r.rc);
          chk("card_ready_in_done", card_ready, 0);
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  initial begin : stimulus
    int k, cyc;
    resetb = 1'b1; start = 1'b0; card_valid = 1'b0; card_value = 4'd0;
    repeat (3) @(negedge clk);
    resetb = 1'b0;
    check_reset();

    cards = '{9, 3, 5, 10, 13, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_round(0);
    cards = '{2, 6, 3, 1, 1, 1, 4, 7, 1, 1, 1, 1, 1, 1, 1, 1};
    run_round(0);
    cards = '{2, 6, 3, 1, 1, 1, 9, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    run_round(2);
    cards = '{9, 3, 5, 10, 13, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_round(1);

    // Abort with reset once the controller asks for player third cards.
    cards = '{2, 6, 3, 1, 1, 1, 4, 7, 1, 1, 1, 1, 1, 1, 1, 1};
    model_round();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; cyc = 0;
    while (!(k == 6 && card_ready) && cyc < Budget) begin
      card_valid = 1'b1;
      card_value = 4'(cards[k]);
      #1;
      if (card_ready && card_valid) k++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= Budget) begin
      checks++; errors++;
      $display("FAIL drawp_timeout: third-card request not seen, k=%0d required 6", k);
    end
    card_valid = 1'b0;
    resetb = 1'b1;
    @(negedge clk);
    resetb = 1'b0;
    check_reset();
    evq.delete();
    resq.delete();
    rounds_done = 0;

    cards = '{9, 3, 5, 10, 13, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_round(0);

    rand_cards();
    cards[0] = 0;
    run_round(2);
    repeat (4) begin
      rand_cards();
      run_round(2);
    end

    repeat (40) begin
      rand_cards();
      run_round(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
